// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pixel/coordinate types and colour constants
// Purpose: common types for the VGA sprite path.
//   pixel_t : RGB444 colour {R[11:8], G[7:4], B[3:0]}
//   coord_t : signed two's-complement screen coordinate
package vga_pkg;

  typedef logic [11:0]        pixel_t;
  typedef logic signed [10:0] coord_t;

  localparam pixel_t COLOR_BLACK = 12'h000;
  localparam pixel_t COLOR_RED   = 12'hF00;
  localparam pixel_t COLOR_GREEN = 12'h0F0;

endpackage

// File: rtl/sprite_rom_mem.sv
// rtl/sprite_rom_mem.sv - SIZE x SIZE checkerboard colour ROM, synchronous read
// Purpose: holds the sprite bitmap and returns one word per clock.
// Ports:
//   clk_i    : pixel clock
//   addr_r_i : local row address (0..SIZE-1)
//   addr_c_i : local column address (0..SIZE-1)
//   data_o   : registered ROM word for the address sampled on the last edge
module sprite_rom_mem
  import vga_pkg::*;
#(
  parameter int SIZE = 40,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_r_i,
  input  logic [AW-1:0] addr_c_i,
  output pixel_t        data_o
);

  localparam int DEPTH = SIZE * SIZE;
  localparam int IW    = $clog2(DEPTH);

  pixel_t         rom [DEPTH];
  logic [IW-1:0]  idx;
  pixel_t         data_d;
  pixel_t         data_q;

  // Constant contents: red where (r+c) is even, green where odd.
  for (genvar gr = 0; gr < SIZE; gr++) begin : g_row
    for (genvar gc = 0; gc < SIZE; gc++) begin : g_col
      assign rom[gr*SIZE + gc] = (((gr + gc) % 2) == 0) ? COLOR_RED : COLOR_GREEN;
    end
  end

  // Row-major flattening; the caller keeps both addresses below SIZE.
  assign idx    = IW'(addr_r_i) * IW'(SIZE) + IW'(addr_c_i);
  assign data_d = rom[idx];

  // No reset: the top masks this register until a valid read has landed.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/sprite_rom_square.sv
// rtl/sprite_rom_square.sv - colour lookup for a fixed square checkerboard sprite
// Purpose: maps a signed (row, column) to RGB444; checkerboard inside the
// square, black outside. One cycle latency, new coordinate every cycle.
// Ports:
//   clk    : pixel clock
//   rst    : asynchronous active-high reset, forces q to black
//   row    : signed pixel row
//   column : signed pixel column
//   q      : pixel colour {R, G, B}, valid one edge after the coordinate
module sprite_rom_square
  import vga_pkg::*;
#(
  parameter int ROW0    = 80,
  parameter int COL0    = 80,
  parameter int SIZE    = 40,
  parameter int COORD_W = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [COORD_W-1:0] row,
  input  logic signed [COORD_W-1:0] column,
  output pixel_t                    q
);

  localparam int AW = $clog2(SIZE);

  localparam logic signed [COORD_W-1:0] ROW_LO = COORD_W'(ROW0);
  localparam logic signed [COORD_W-1:0] ROW_HI = COORD_W'(ROW0 + SIZE);
  localparam logic signed [COORD_W-1:0] COL_LO = COORD_W'(COL0);
  localparam logic signed [COORD_W-1:0] COL_HI = COORD_W'(COL0 + SIZE);

  logic          in_win_d;
  logic          in_win_q;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_c;
  pixel_t        rom_data;

  // Signed compares: negative coordinates fall below the low bounds.
  assign in_win_d = (row >= ROW_LO) && (row < ROW_HI) &&
                    (column >= COL_LO) && (column < COL_HI);

  // Outside the window the address is parked at 0 so the ROM is never
  // indexed past its end; the colour is masked to black anyway.
  assign addr_r = in_win_d ? AW'(row - ROW_LO)    : '0;
  assign addr_c = in_win_d ? AW'(column - COL_LO) : '0;

  sprite_rom_mem #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_mem (
    .clk_i    (clk),
    .addr_r_i (addr_r),
    .addr_c_i (addr_c),
    .data_o   (rom_data)
  );

  // The window flag is registered alongside the ROM read so both line up;
  // clearing it asynchronously blanks q the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_win_q <= 1'b0;
    end else begin
      in_win_q <= in_win_d;
    end
  end

  assign q = in_win_q ? rom_data : COLOR_BLACK;

endmodule

// File: tb/tb_sprite_rom_square.sv
// tb/tb_sprite_rom_square.sv - self-checking bench for sprite_rom_square
module tb_sprite_rom_square;

  localparam int ROW0 = 80;
  localparam int COL0 = 80;
  localparam int SIZE = 40;
  localparam int CW   = 11;

  logic                 clk;
  logic                 rst;
  logic signed [CW-1:0] row;
  logic signed [CW-1:0] column;
  logic [11:0]          q;

  int checks   = 0;
  int failures = 0;

  sprite_rom_square #(
    .ROW0    (ROW0),
    .COL0    (COL0),
    .SIZE    (SIZE),
    .COORD_W (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .row    (row),
    .column (column),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: square membership plus parity of the offset from the origin.
  function automatic logic [11:0] model(input int r, input int c);
    if (r >= ROW0 && r < ROW0 + SIZE && c >= COL0 && c < COL0 + SIZE)
      return (((r - ROW0) + (c - COL0)) % 2 == 0) ? 12'hF00 : 12'h0F0;
    return 12'h000;
  endfunction

  task automatic check(input logic [11:0] obs, input logic [11:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge sample, check at the next fall.
  task automatic step(input int r, input int c, input string tag);
    row    = CW'(r);
    column = CW'(c);
    @(posedge clk);
    @(negedge clk);
    check(q, model(r, c), tag);
  endtask

  initial begin
    int rr;
    int cc;

    rst    = 1'b1;
    row    = CW'(100);
    column = CW'(100);
    #1;
    check(q, 12'h000, "reset_no_edge");
    repeat (2) @(negedge clk);
    check(q, 12'h000, "reset_held");
    rst = 1'b0;
    step(0, 0, "post_reset_0_0");

    step(0, 0, "out_0_0");
    step(700, 500, "out_700_500");
    step(-10, -10, "out_neg10");
    check(q, 12'h000, "out_neg10_const");

    step(100, 100, "chk_100_100");
    check(q, 12'hF00, "chk_100_100_const");
    step(100, 101, "chk_100_101");
    check(q, 12'h0F0, "chk_100_101_const");
    step(101, 100, "chk_101_100");
    step(101, 101, "chk_101_101");

    step(90, 90, "off_90_90");
    step(90, 91, "off_90_91");
    step(91, 90, "off_91_90");
    step(91, 91, "off_91_91");

    step(80, 80, "bnd_80_80");
    check(q, 12'hF00, "bnd_80_80_const");
    step(119, 119, "bnd_119_119");
    step(120, 100, "bnd_120_100");
    check(q, 12'h000, "bnd_120_100_const");
    step(100, 120, "bnd_100_120");
    step(79, 100, "bnd_79_100");
    step(80, 119, "bnd_80_119");
    step(119, 80, "bnd_119_80");
    step(100, 79, "bnd_100_79");

    for (int i = 0; i < 8; i++) begin
      step(100, (i % 2 == 0) ? 100 : 101, "stream_alt");
    end

    // Mid-stream reset: q must drop before any further clock edge.
    row    = CW'(100);
    column = CW'(101);
    rst    = 1'b1;
    #1;
    check(q, 12'h000, "midstream_reset_async");
    @(negedge clk);
    check(q, 12'h000, "midstream_reset_held");
    rst = 1'b0;
    step(100, 100, "first_after_reset");
    step(100, 101, "second_after_reset");

    for (int i = 0; i < 300; i++) begin
      rr = int'($urandom_range(0, 160)) - 20;
      cc = int'($urandom_range(0, 160)) - 20;
      step(rr, cc, "rand_near");
    end
    for (int i = 0; i < 100; i++) begin
      rr = int'($urandom_range(0, 2047)) - 1024;
      cc = int'($urandom_range(0, 2047)) - 1024;
      step(rr, cc, "rand_full");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
